// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file.
//   DATA_W_DEF : default register / data-port width
//   NUM_REGS   : default register count (entry 0 is the constant zero register)
//   ADDR_W     : read-address width
//   EN_W       : width of the one-hot write-enable vector
//   CNT_W      : width of the committed-write counter
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned EN_W       = 32;
  localparam int unsigned CNT_W      = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [EN_W-1:0] v);
    return (v != '0) && ((v & (v - EN_W'(1))) == '0);
  endfunction

  // Bit k set when register k physically exists (k in 1..n-1).
  function automatic logic [EN_W-1:0] reg_mask(input int unsigned n);
    logic [EN_W-1:0] m;
    m = '0;
    for (int unsigned k = 1; k < EN_W; k++) begin
      m[k] = (k < n);
    end
    return m;
  endfunction

endpackage : regfile_pkg

// File: rtl/regcell.sv
// Single DataWidth-bit storage register with write enable and async clear.
//   clk_i : clock
//   rst_i : asynchronous active-high clear
//   en_i  : load d_i on the rising edge
//   d_i   : write data
//   q_o   : stored value
module regcell
  import regfile_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [DataWidth-1:0] d_i,
  output logic [DataWidth-1:0] q_o
);

  logic [DataWidth-1:0] data_q;
  logic [DataWidth-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = d_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule : regcell

// File: rtl/register_file.sv
// Two-read / one-write register file with one-hot write enables, a sticky
// illegal-enable flag, write-through bypass and a saturating write counter.
//   Clk           : clock, all state updates on the rising edge
//   Reset         : asynchronous active-high clear of all state
//   WriteEn       : one-hot write enables (bit 0 is ignored)
//   WriteData     : write data
//   ReadRegister1 : read port 1 address
//   ReadRegister2 : read port 2 address
//   ReadData1     : read port 1 data (combinational, with bypass)
//   ReadData2     : read port 2 data (combinational, with bypass)
//   OneHotErr     : sticky flag, set by a multi-bit WriteEn, blocks all writes
//   WriteCount    : saturating count of committed writes
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_W_DEF,
  parameter int unsigned NumRegs   = NUM_REGS
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [EN_W-1:0]      WriteEn,
  input  logic [DataWidth-1:0] WriteData,
  input  logic [ADDR_W-1:0]    ReadRegister1,
  input  logic [ADDR_W-1:0]    ReadRegister2,
  output logic [DataWidth-1:0] ReadData1,
  output logic [DataWidth-1:0] ReadData2,
  output logic                 OneHotErr,
  output logic [CNT_W-1:0]     WriteCount
);

  localparam logic [EN_W-1:0] REG_MASK = reg_mask(NumRegs);

  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [EN_W-1:0]      en_hi_c;
  logic                 multi_c;
  logic                 legal_c;
  logic [DataWidth-1:0] regs_c [EN_W];

  // Bit 0 targets the zero register and takes no part in legality.
  assign en_hi_c = {WriteEn[EN_W-1:1], 1'b0};
  assign multi_c = (en_hi_c != '0) && !is_onehot(en_hi_c);

  // A write commits only outside reset, with no sticky error, to an existing register.
  assign legal_c = !Reset && !err_q && is_onehot(en_hi_c) && ((en_hi_c & REG_MASK) != '0);

  // Register storage: entry 0 is hard-wired zero.
  assign regs_c[0] = '0;
  for (genvar k = 1; k < EN_W; k++) begin : g_reg
    if (k < NumRegs) begin : g_cell
      regcell #(.DataWidth(DataWidth)) u_cell (
        .clk_i (Clk),
        .rst_i (Reset),
        .en_i  (legal_c & WriteEn[k]),
        .d_i   (WriteData),
        .q_o   (regs_c[k])
      );
    end else begin : g_none
      assign regs_c[k] = '0;
    end
  end

  // Read muxes; legal_c being one-hot means WriteEn[addr] identifies the target.
  always_comb begin
    ReadData1 = regs_c[ReadRegister1];
    ReadData2 = regs_c[ReadRegister2];
    if (legal_c && (ReadRegister1 != '0) && WriteEn[ReadRegister1]) ReadData1 = WriteData;
    if (legal_c && (ReadRegister2 != '0) && WriteEn[ReadRegister2]) ReadData2 = WriteData;
    if (Reset) begin
      ReadData1 = '0;
      ReadData2 = '0;
    end
  end

  // Sticky error and saturating commit counter.
  always_comb begin
    err_d = err_q | multi_c;
    cnt_d = cnt_q;
    if (legal_c && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign OneHotErr  = err_q;
  assign WriteCount = cnt_q;

endmodule : register_file
